// File: rtl/z80_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | z80_bus_pkg                                                              |
// | Shared Z80 I/O bus constants, defaults and sequencer state encoding.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package z80_bus_pkg;

    localparam logic [7:0] c_PORT_ADDR_LO = 8'h40;
    localparam logic [7:0] c_PORT_ADDR_HI = 8'h41;
    localparam logic [7:0] c_PORT_VALUE   = 8'h42;

    localparam int c_DEF_CLK_DIV    = 4;
    localparam int c_DEF_TW_STATES  = 1;
    localparam int c_DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_HOLD = 3'd5
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/z80_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | z80_cmd_fifo                                                             |
// | Command FIFO, first-word fall-through; full/empty from occupancy count.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module z80_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Requests are qualified here so a push while full can never corrupt an entry.
    assign full     = (r_count == c_CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk25) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/z80_io_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | z80_io_master                                                            |
// | Queued Z80 I/O write master: clock divider plus T1/T2/TW/T3 sequencer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module z80_io_master
    import z80_bus_pkg::*;
#(
    parameter int CLK_DIV    = c_DEF_CLK_DIV,
    parameter int TW_STATES  = c_DEF_TW_STATES,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       z80_clk,
    output logic [7:0] a,
    output logic [7:0] d,
    output logic       d_oe,
    output logic       iorq_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       mreq_n,
    output logic       busy,
    output logic       done
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_TW_W  = (TW_STATES > 1) ? $clog2(TW_STATES) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_TW_W-1:0]  c_TW_LAST  = c_TW_W'((TW_STATES > 0) ? TW_STATES - 1 : 0);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_z80_clk;
    logic               w_tick;
    logic               w_rise_tick;
    logic               w_fall_tick;

    bus_state_t         r_state;
    bus_state_t         w_state;
    logic [7:0]         r_a;
    logic [7:0]         w_a;
    logic [7:0]         r_d;
    logic [7:0]         w_d;
    logic               r_d_oe;
    logic               w_d_oe;
    logic               r_strobe;
    logic               w_strobe;
    logic               r_done;
    logic               w_done;
    logic [c_TW_W-1:0]  r_tw_cnt;
    logic [c_TW_W-1:0]  w_tw_cnt;

    logic               w_pop;
    logic [15:0]        w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    z80_cmd_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data ({cmd_port, cmd_data}),
        .pop       (w_pop),
        .pop_data  (w_fifo_dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_rise_tick = w_tick && !r_z80_clk;
    assign w_fall_tick = w_tick && r_z80_clk;

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_z80_clk <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_z80_clk <= ~r_z80_clk;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    always_comb begin
        w_state  = r_state;
        w_a      = r_a;
        w_d      = r_d;
        w_d_oe   = r_d_oe;
        w_strobe = r_strobe;
        w_done   = 1'b0;
        w_tw_cnt = r_tw_cnt;
        w_pop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise_tick && !w_fifo_empty) begin
                    w_pop   = 1'b1;
                    w_a     = w_fifo_dout[15:8];
                    w_d     = w_fifo_dout[7:0];
                    w_d_oe  = 1'b1;
                    w_state = ST_T1;
                end
            end
            ST_T1: begin
                if (w_rise_tick) begin
                    w_strobe = 1'b1;
                    w_state  = ST_T2;
                end
            end
            ST_T2: begin
                if (w_rise_tick) begin
                    w_tw_cnt = '0;
                    w_state  = (TW_STATES == 0) ? ST_T3 : ST_TW;
                end
            end
            ST_TW: begin
                if (w_rise_tick) begin
                    if (r_tw_cnt == c_TW_LAST) begin
                        w_state = ST_T3;
                    end else begin
                        w_tw_cnt = r_tw_cnt + c_TW_W'(1);
                    end
                end
            end
            ST_T3: begin
                if (w_fall_tick) begin
                    w_strobe = 1'b0;
                    w_done   = 1'b1;
                    w_state  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Back-to-back writes keep the data bus driven across the seam.
                if (w_rise_tick) begin
                    if (!w_fifo_empty) begin
                        w_pop   = 1'b1;
                        w_a     = w_fifo_dout[15:8];
                        w_d     = w_fifo_dout[7:0];
                        w_state = ST_T1;
                    end else begin
                        w_d_oe  = 1'b0;
                        w_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_d      <= '0;
            r_d_oe   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_tw_cnt <= '0;
        end else begin
            r_state  <= w_state;
            r_a      <= w_a;
            r_d      <= w_d;
            r_d_oe   <= w_d_oe;
            r_strobe <= w_strobe;
            r_done   <= w_done;
            r_tw_cnt <= w_tw_cnt;
        end
    end

    // One register drives both strobes so they can never disagree.
    assign iorq_n    = ~r_strobe;
    assign wr_n      = ~r_strobe;
    assign rd_n      = 1'b1;
    assign mreq_n    = 1'b1;
    assign z80_clk   = r_z80_clk;
    assign a         = r_a;
    assign d         = r_d;
    assign d_oe      = r_d_oe;
    assign done      = r_done;
    assign cmd_ready = ~w_fifo_full;
    assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_z80_io_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_z80_io_master                                                         |
// | Two configurations against a timeline model of queued Z80 I/O writes.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_z80_io_master;
    import z80_bus_pkg::*;

    localparam int FDEPTH = 4;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_port;
    logic [7:0] cmd_data;

    logic       zc [2];
    logic [7:0] ab [2];
    logic [7:0] db [2];
    logic       doe [2];
    logic       iorqn [2];
    logic       wrn [2];
    logic       rdn [2];
    logic       mreqn [2];
    logic       bsy [2];
    logic       dn [2];
    logic       rdy [2];

    int total = 0;
    int bad   = 0;

    always #20 clk25 = ~clk25;

    z80_io_master #(.CLK_DIV(4), .TW_STATES(1), .FIFO_DEPTH(FDEPTH)) u_dut0 (
        .clk25(clk25), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
        .cmd_port(cmd_port), .cmd_data(cmd_data), .z80_clk(zc[0]), .a(ab[0]), .d(db[0]),
        .d_oe(doe[0]), .iorq_n(iorqn[0]), .wr_n(wrn[0]), .rd_n(rdn[0]), .mreq_n(mreqn[0]),
        .busy(bsy[0]), .done(dn[0]));

    z80_io_master #(.CLK_DIV(2), .TW_STATES(0), .FIFO_DEPTH(FDEPTH)) u_dut1 (
        .clk25(clk25), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
        .cmd_port(cmd_port), .cmd_data(cmd_data), .z80_clk(zc[1]), .a(ab[1]), .d(db[1]),
        .d_oe(doe[1]), .iorq_n(iorqn[1]), .wr_n(wrn[1]), .rd_n(rdn[1]), .mreq_n(mreqn[1]),
        .busy(bsy[1]), .done(dn[1]));

    function automatic int cd_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int tw_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Model: edges counted from reset; a write started on rise edge S occupies
    // S .. S+(3+TW)*P, strobes low over [S+P, S+(2+TW)*P+CLK_DIV).
    int          n_cnt [2];
    int          q_head [2];
    int          q_tail [2];
    logic [15:0] q_mem [2][256];
    bit          in_cyc [2];
    int          s_edge [2];
    logic [15:0] cur [2];
    bit          model_live = 1'b0;
    int          m_cd, m_per, m_occ;
    bit          m_rise;

    always @(posedge clk25) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                n_cnt[i]  = 0;
                q_head[i] = 0;
                q_tail[i] = 0;
                in_cyc[i] = 1'b0;
                s_edge[i] = 0;
            end else begin
                n_cnt[i] = n_cnt[i] + 1;
                m_cd     = cd_of(i);
                m_per    = 2 * m_cd;
                m_occ    = q_tail[i] - q_head[i];
                m_rise   = (n_cnt[i] % m_cd == 0) && ((n_cnt[i] / m_cd) % 2 == 1);
                if (m_rise && (!in_cyc[i] || n_cnt[i] == s_edge[i] + (3 + tw_of(i)) * m_per)) begin
                    if (m_occ > 0) begin
                        cur[i]    = q_mem[i][q_head[i] % 256];
                        q_head[i] = q_head[i] + 1;
                        in_cyc[i] = 1'b1;
                        s_edge[i] = n_cnt[i];
                    end else begin
                        in_cyc[i] = 1'b0;
                    end
                end
                if (cmd_valid && m_occ < FDEPTH) begin
                    q_mem[i][q_tail[i] % 256] = {cmd_port, cmd_data};
                    q_tail[i] = q_tail[i] + 1;
                end
            end
        end
        model_live = 1'b1;
    end

    int         e_cd, e_per, e_lo, e_hi;
    bit         e_stb, e_done;
    logic [8:0] e_ctl, a_ctl;

    always @(negedge clk25) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                e_cd   = cd_of(i);
                e_per  = 2 * e_cd;
                e_lo   = s_edge[i] + e_per;
                e_hi   = s_edge[i] + (2 + tw_of(i)) * e_per + e_cd;
                e_stb  = in_cyc[i] && n_cnt[i] >= e_lo && n_cnt[i] < e_hi;
                e_done = in_cyc[i] && n_cnt[i] == e_hi;
                e_ctl  = {1'((n_cnt[i] / e_cd) % 2), ~e_stb, ~e_stb, 1'b1, 1'b1, in_cyc[i], e_done,
                          in_cyc[i] || (q_tail[i] != q_head[i]), (q_tail[i] - q_head[i]) < FDEPTH};
                a_ctl  = {zc[i], iorqn[i], wrn[i], rdn[i], mreqn[i], doe[i], dn[i], bsy[i], rdy[i]};
                total++;
                if (a_ctl !== e_ctl) begin
                    bad++;
                    $display("FAIL ctl dut%0d t=%0t: got %b want %b (clk,iorq_n,wr_n,rd_n,mreq_n,d_oe,done,busy,ready)",
                             i, $time, a_ctl, e_ctl);
                end
                if (in_cyc[i]) begin
                    total++;
                    if ({ab[i], db[i]} !== cur[i]) begin
                        bad++;
                        $display("FAIL bus dut%0d t=%0t: got a/d %h want %h", i, $time, {ab[i], db[i]}, cur[i]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    int         w_stb [2];
    int         w_doe [2];
    int         w_done [2];
    int         w_rise [2];
    int         w_n [2];
    logic [7:0] w_a [2][8];
    logic [7:0] w_d [2][8];
    int         w_t [2][8];

    task automatic watch(input int cycles);
        bit pstb [2];
        bit pdoe [2];
        bit stb;
        for (int i = 0; i < 2; i++) begin
            w_stb[i] = 0; w_doe[i] = 0; w_done[i] = 0; w_rise[i] = 0; w_n[i] = 0;
            pstb[i] = 1'b0; pdoe[i] = 1'b0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk25);
            for (int i = 0; i < 2; i++) begin
                stb = !iorqn[i];
                if (stb) w_stb[i]++;
                if (doe[i]) w_doe[i]++;
                if (dn[i]) w_done[i]++;
                if (doe[i] && !pdoe[i]) w_rise[i]++;
                if (stb && !pstb[i]) begin
                    if (w_n[i] < 8) begin
                        w_a[i][w_n[i]] = ab[i];
                        w_d[i][w_n[i]] = db[i];
                        w_t[i][w_n[i]] = c;
                    end
                    w_n[i]++;
                end
                pstb[i] = stb;
                pdoe[i] = doe[i];
            end
        end
    endtask

    task automatic push1(input logic [7:0] p, input logic [7:0] v);
        @(negedge clk25);
        cmd_valid = 1'b1;
        cmd_port  = p;
        cmd_data  = v;
    endtask

    int  rst_hold;
    bit  found;
    logic [7:0] ports3 [3];
    logic [7:0] datas3 [3];

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_port = 8'h00; cmd_data = 8'h00;
        repeat (3) @(negedge clk25);
        check("reset_ready", int'(rdy[0]), 1);
        check("reset_busy", int'(bsy[0]), 0);
        check("reset_iorq_n", int'(iorqn[0]), 1);
        check("reset_d_oe", int'(doe[1]), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk25);

        // Single write to the value port.
        push1(c_PORT_VALUE, 8'hAA);
        @(negedge clk25);
        cmd_valid = 1'b0;
        watch(200);
        check("single_stb_len0", w_stb[0], 20);
        check("single_doe_len0", w_doe[0], 32);
        check("single_done0", w_done[0], 1);
        check("single_writes0", w_n[0], 1);
        check("single_a0", int'(w_a[0][0]), 8'h42);
        check("single_d0", int'(w_d[0][0]), 8'hAA);
        check("single_stb_len1", w_stb[1], 6);
        check("single_doe_len1", w_doe[1], 12);
        check("single_done1", w_done[1], 1);

        // Three back-to-back writes.
        ports3 = '{c_PORT_ADDR_LO, c_PORT_ADDR_HI, c_PORT_VALUE};
        datas3 = '{8'h12, 8'h34, 8'h56};
        for (int k = 0; k < 3; k++) push1(ports3[k], datas3[k]);
        @(negedge clk25);
        cmd_valid = 1'b0;
        watch(300);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("b2b_writes%0d", i), w_n[i], 3);
            check($sformatf("b2b_doe_rises%0d", i), w_rise[i], 1);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("b2b_a%0d_%0d", i, k), int'(w_a[i][k]), int'(ports3[k]));
                check($sformatf("b2b_d%0d_%0d", i, k), int'(w_d[i][k]), int'(datas3[k]));
            end
        end
        check("b2b_period0a", w_t[0][1] - w_t[0][0], 32);
        check("b2b_period0b", w_t[0][2] - w_t[0][1], 32);
        check("b2b_period1a", w_t[1][1] - w_t[1][0], 12);

        // Overfill straight out of reset.
        @(negedge clk25);
        rst_n = 1'b0;
        repeat (2) @(negedge clk25);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk25);
            if (k == 5) begin
                check("full_ready0", int'(rdy[0]), 0);
                check("full_ready1", int'(rdy[1]), 0);
            end
            rst_n = 1'b1; cmd_valid = 1'b1; cmd_port = 8'(8'h10 + k); cmd_data = 8'(8'hC0 + k);
        end
        @(negedge clk25);
        cmd_valid = 1'b0;
        watch(400);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("full_writes%0d", i), w_n[i], 5);
            check($sformatf("full_first%0d", i), int'(w_a[i][0]), 8'h10);
            check($sformatf("full_last%0d", i), int'({w_a[i][4], w_d[i][4]}), 16'h14C4);
        end

        // Reset while in T2.
        push1(8'h42, 8'h5A);
        @(negedge clk25);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk25);
            if (!iorqn[0]) found = 1'b1;
        end
        check("t2_reached", int'(found), 1);
        @(negedge clk25);
        rst_n = 1'b0;
        @(negedge clk25);
        check("abort_iorq_n", int'(iorqn[0]), 1);
        check("abort_wr_n", int'(wrn[0]), 1);
        check("abort_d_oe", int'(doe[0]), 0);
        check("abort_done", int'(dn[0]), 0);
        check("abort_ready", int'(rdy[0]), 1);
        check("abort_busy", int'(bsy[0]), 0);
        rst_n = 1'b1;
        watch(60);
        check("abort_no_stb", w_stb[0], 0);
        check("abort_no_done", w_done[0], 0);

        // Random traffic with occasional resets.
        rst_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk25);
            if (rst_hold > 0) begin
                rst_hold--;
                rst_n = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_hold = int'($urandom_range(0, 2));
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_port  = 8'($urandom);
            cmd_data  = 8'($urandom);
        end
        @(negedge clk25);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        repeat (300) @(negedge clk25);
        check("drain_busy0", int'(bsy[0]), 0);
        check("drain_busy1", int'(bsy[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
